// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared types and helpers for the UART TX arbiter and for
//                any later RX demux that reuses the round-robin search.
//                - arb_state_e : arbiter FSM encoding
//                - MAX_NREQ    : largest supported requester count
//                - rr_pick()   : round-robin search returning index + found
//  Revision    : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam int MAX_IDW  = 3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HDR  = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] at or above ptr, wrapping at n.
  // Offsets are walked from the farthest down to the nearest so the
  // nearest hit is the last one written and therefore wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                       input logic [MAX_IDW-1:0]  ptr,
                                       input int                  n);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) begin
          j = j - n;
        end
        if (req[3'(j)]) begin
          res.found = 1'b1;
          res.idx   = MAX_IDW'(j);
        end
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_pick
//  Description : Combinational round-robin search over a request vector.
//  Ports       : req   in  NREQ  request bits
//                ptr   in  IDW   highest-priority index
//                idx   out IDW   selected index (0 when nothing found)
//                found out 1     at least one request bit set
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_NREQ'(req), MAX_IDW'(ptr), NREQ);
    idx   = IDW'(pick.idx);
    found = pick.found;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arb
//  Description : Round-robin packet arbiter sharing one uart_core TX path
//                between NREQ requesters. A grant is held from the first byte
//                until a byte flagged last is accepted.
//  Ports       : clk, rst                   clock, sync active-high reset
//                req_valid/req_data/req_last requester byte streams (packed)
//                req_ready                   per-requester accept strobe
//                txdin/txvalid/ready         uart_core TX handshake
//                gnt_id                      current owner (valid when busy)
//                busy                        packet in progress
//  Config      : UART_ARB_ID_HDR_EN - when defined, each packet is prefixed
//                on the line by one byte carrying the owner index.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        txdin,
  output logic              txvalid,
  input  logic              ready,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = ARB_IDLE;
  localparam logic [1:0] ST_DATA = ARB_DATA;
`ifdef UART_ARB_ID_HDR_EN
  localparam logic [1:0] ST_HDR  = ARB_HDR;
`endif

  logic [1:0]     state_q,  state_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           busy_q,   busy_d;

  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic           own_valid;
  logic           own_last;
  logic [7:0]     own_data;

  uart_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    own_valid = req_valid[gnt_id_q];
    own_last  = req_last[gnt_id_q];
    own_data  = req_data[{gnt_id_q, 3'b000} +: 8];

    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    rr_ptr_d  = rr_ptr_q;
    busy_d    = busy_q;
    txvalid   = 1'b0;
    txdin     = 8'h00;
    req_ready = '0;

    case (state_q)
      ST_IDLE: begin
        // Outputs stay quiet here: this is the one-cycle arbitration bubble.
        if (pick_found) begin
          gnt_id_d = pick_idx;
          busy_d   = 1'b1;
`ifdef UART_ARB_ID_HDR_EN
          state_d  = ST_HDR;
`else
          state_d  = ST_DATA;
`endif
        end
      end
`ifdef UART_ARB_ID_HDR_EN
      ST_HDR: begin
        txvalid = 1'b1;
        txdin   = 8'(gnt_id_q);
        if (ready) begin
          state_d = ST_DATA;
        end
      end
`endif
      ST_DATA: begin
        // Only the owner is passed through; other requesters wait for IDLE.
        txvalid = own_valid;
        txdin   = own_valid ? own_data : 8'h00;
        req_ready[gnt_id_q] = own_valid & ready;
        if (own_valid && ready && own_last) begin
          rr_ptr_d = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arb
//  Description : Self-checking bench for uart_tx_arb (NREQ=4). Requesters
//                are byte queues; uart_core is a ready stub. A packet-level
//                model predicts the outputs every cycle and per-requester
//                byte streams are compared against what appeared on the line.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef UART_ARB_ID_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_data  = '0;
  logic [NREQ-1:0]   req_last  = '0;
  logic              ready     = 1'b0;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        txdin;
  logic              txvalid;
  logic [IDW-1:0]    gnt_id;
  logic              busy;

  uart_tx_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .txdin     (txdin),
    .txvalid   (txvalid),
    .ready     (ready),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IDW-1:0] ix(input int v);
    return IDW'(v);
  endfunction

  function automatic int at(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  // Requester byte queues {last, byte}, and sent/received streams.
  logic [8:0] txq   [NREQ][$];
  logic [7:0] exp_s [NREQ][$];
  logic [7:0] got_s [NREQ][$];

  task automatic push_byte(input int i, input logic [7:0] b, input logic l);
    txq[ix(i)].push_back({l, b});
    exp_s[ix(i)].push_back(b);
  endtask

  task automatic push_pkt(input int i, input int len);
    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), (b == len - 1));
  endtask

  function automatic bit q_empty();
    for (int i = 0; i < NREQ; i++) if (txq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- packet-level model ----------------
  int m_owner = -1;   // requester owning the line, -1 when nobody
  int m_ptr   = 0;    // first requester to consider at the next arbitration
  bit m_hdr   = 1'b0; // owner's index byte still to be sent

  // Stimulus controls.
  int            rdy_mode  = 1;   // 0 low, 1 high, 2 random
  bit [NREQ-1:0] gap_force = '0;
  bit            gap_rand  = 1'b0;
  bit            chk_on    = 1'b0;

  // Logs filled by the compare process.
  int line_log[$];    // owner*256 + byte for payload bytes
  int line_cyc[$];
  int hdr_log[$];
  int grant_log[$];
  int n_xfer = 0;
  int cyc    = 0;
  int acc_cnt[NREQ] = '{default: 0};
  bit prev_busy = 1'b0;

  // Model step and requester/uart stub drive.
  logic [8:0] popped;
  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hdr   = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++)
        if (m_owner < 0 && req_valid[ix((m_ptr + k) % NREQ)]) m_owner = (m_ptr + k) % NREQ;
      m_hdr = HDR && (m_owner >= 0);
    end else if (m_hdr) begin
      if (ready) m_hdr = 1'b0;
    end else if (req_valid[ix(m_owner)] && ready) begin
      popped = txq[ix(m_owner)].pop_front();
      if (req_last[ix(m_owner)]) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
    chk_on = 1'b1;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      bit g;
      g = gap_force[i] || (gap_rand && ($urandom_range(4) == 0));
      if (txq[i].size() > 0 && !g) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = txq[i][0][7:0];
        req_last[i]         = txq[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
    end
    ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(9) < 7);
  end

  // Compare process: outputs versus model, then logging.
  bit              e_valid;
  logic [7:0]      e_din;
  logic [NREQ-1:0] e_rdy;
  always @(negedge clk) begin
    if (chk_on) begin
      cyc++;
      e_valid = 1'b0;
      e_din   = 8'h00;
      e_rdy   = '0;
      if (m_owner >= 0) begin
        if (m_hdr) begin
          e_valid = 1'b1;
          e_din   = 8'(m_owner);
        end else if (req_valid[ix(m_owner)]) begin
          e_valid = 1'b1;
          e_din   = 8'(req_data >> (8 * m_owner));
          if (ready) e_rdy[ix(m_owner)] = 1'b1;
        end
      end
      chk("txvalid", int'(txvalid), int'(e_valid));
      chk("txdin", int'(txdin), int'(e_din));
      chk("req_ready", int'(req_ready), int'(e_rdy));
      chk("busy", int'(busy), int'(m_owner >= 0));
      if (m_owner >= 0) chk("gnt_id", int'(gnt_id), m_owner);
      chk("req_ready_onehot", int'($countones(req_ready) <= 1), 1);

      if (txvalid && ready) begin
        n_xfer++;
        if (m_owner >= 0) begin
          if (m_hdr) hdr_log.push_back(int'(txdin));
          else begin
            line_log.push_back(m_owner * 256 + int'(txdin));
            line_cyc.push_back(cyc);
            got_s[ix(m_owner)].push_back(txdin);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) acc_cnt[i]++;
      if (busy && !prev_busy) grant_log.push_back(int'(gnt_id));
      prev_busy = busy;
    end
  end

  // ---------------- helpers for directed tests ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string name, input int maxc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      tick(1);
      done = (m_owner < 0) && !busy && q_empty();
    end
    chk(name, int'(done), 1);
  endtask

  task automatic wait_xfer(input string name, input int target, input int maxc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      tick(1);
      done = (n_xfer >= target);
    end
    chk(name, int'(done), 1);
  endtask

  task automatic clear_logs();
    line_log.delete();
    line_cyc.delete();
    hdr_log.delete();
    grant_log.delete();
  endtask

  // ---------------- test sequence ----------------
  int base;
  int x0;
  int a0;
  int exp_g[5] = '{0, 1, 2, 3, 0};
  int exp_l[5] = '{32'h0C0, 32'h1C1, 32'h2C2, 32'h3C3, 32'h0C4};

  initial begin
    // Reset with every requester valid, then all four race from reset.
    push_byte(0, 8'hC0, 1'b1);
    push_byte(1, 8'hC1, 1'b1);
    push_byte(2, 8'hC2, 1'b1);
    push_byte(3, 8'hC3, 1'b1);
    push_byte(0, 8'hC4, 1'b1);
    tick(4);
    chk("rst_txvalid", int'(txvalid), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    chk("rst_txdin", int'(txdin), 0);
    rst = 1'b0;
    wait_idle("rr_idle", 100);
    chk("rr_grants", grant_log.size(), 5);
    for (int k = 0; k < 5; k++) chk("rr_grant_order", at(grant_log, k), exp_g[k]);
    for (int k = 0; k < 5; k++) chk("rr_line_bytes", at(line_log, k), exp_l[k]);
    chk("rr_ptr_after", m_ptr, 1);

    // Single client, two-byte packet.
    clear_logs();
    a0 = acc_cnt[2];
    push_byte(2, 8'h55, 1'b0);
    push_byte(2, 8'hA3, 1'b1);
    wait_idle("single_idle", 50);
    chk("single_b0", at(line_log, 0), 32'h255);
    chk("single_b1", at(line_log, 1), 32'h2A3);
    chk("single_consecutive", at(line_cyc, 1) - at(line_cyc, 0), 1);
    chk("single_ready_pulses", acc_cnt[2] - a0, 2);
    chk("single_ptr", m_ptr, 3);

    // Packet lock: owner gaps mid-packet, a waiting requester must not cut in.
    clear_logs();
    base = n_xfer;
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h22, 1'b0);
    push_byte(0, 8'h33, 1'b1);
    push_byte(1, 8'h44, 1'b1);
    wait_xfer("lock_first", base + (HDR ? 2 : 1), 50);
    gap_force[0] = 1'b1;
    tick(5);
    gap_force[0] = 1'b0;
    wait_idle("lock_idle", 100);
    chk("lock_b0", at(line_log, 0), 32'h011);
    chk("lock_b1", at(line_log, 1), 32'h022);
    chk("lock_b2", at(line_log, 2), 32'h033);
    chk("lock_b3", at(line_log, 3), 32'h144);

    // Backpressure: ready low 20 cycles mid-packet.
    clear_logs();
    base = n_xfer + (HDR ? 1 : 0);
    for (int b = 0; b < 5; b++) push_byte(3, 8'hB0 + 8'(b), (b == 4));
    wait_xfer("bp_start", base + 2, 50);
    rdy_mode = 0;
    tick(1);
    x0 = n_xfer;
    tick(20);
    chk("bp_hold_no_xfer", n_xfer, x0);
    chk("bp_hold_busy", int'(busy), 1);
    rdy_mode = 1;
    tick(1);
    chk("bp_before_rise", n_xfer, x0);
    tick(1);
    chk("bp_one_xfer", n_xfer, x0 + 1);
    wait_idle("bp_idle", 50);
    for (int k = 0; k < 5; k++) chk("bp_bytes", at(line_log, k), 32'h3B0 + k);

`ifdef UART_ARB_ID_HDR_EN
    // Header byte carries the source index ahead of the payload.
    clear_logs();
    a0 = acc_cnt[3];
    push_byte(3, 8'h7E, 1'b1);
    wait_idle("hdr_idle", 50);
    chk("hdr_count", hdr_log.size(), 1);
    chk("hdr_byte", at(hdr_log, 0), 32'h03);
    chk("hdr_payload", at(line_log, 0), 32'h37E);
    chk("hdr_ready_pulses", acc_cnt[3] - a0, 1);
`else
    chk("no_hdr_bytes", hdr_log.size(), 0);
`endif

    // Randomized traffic with random ready and valid gaps.
    rdy_mode = 2;
    gap_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      if ($urandom_range(5) == 0) begin
        int i;
        i = int'($urandom_range(NREQ - 1));
        if (txq[ix(i)].size() < 12) push_pkt(i, int'($urandom_range(4, 1)));
      end
    end
    rdy_mode = 1;
    gap_rand = 1'b0;
    wait_idle("rand_drain", 3000);

    // Per-requester streams: everything sent must appear on the line in order.
    for (int i = 0; i < NREQ; i++) begin
      chk("stream_len", got_s[i].size(), exp_s[i].size());
      for (int k = 0; k < exp_s[i].size() && k < got_s[i].size(); k++)
        chk("stream_byte", int'(got_s[i][k]), int'(exp_s[i][k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
